// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared bus constants used by the transmit queue and the bus
//                requester: default data width, default queue depth and the
//                width of an occupancy counter that can hold 0..depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_bus_n     = 8;
    localparam int c_bus_depth = 4;

    // A counter that must represent 0..depth inclusive needs one more code
    // than an address into a depth-entry array.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int c_bus_cnt_w = cnt_width(c_bus_depth);

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_txq_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bus_txq_mem
//  Description : DEPTH x N register array for the transmit queue. One
//                synchronous write port, one asynchronous read port. Storage
//                is deliberately not reset; the owner masks it while empty.
//  Ports       : clk     - clock
//                i_we    - write enable
//                i_waddr - write address
//                i_wdata - write data
//                i_raddr - read address
//                o_rdata - read data (combinational from i_raddr)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_txq_mem
    import bus_pkg::*;
#(
    parameter int N     = c_bus_n,
    parameter int DEPTH = c_bus_depth
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [N-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [N-1:0]             o_rdata
);

    logic [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : bus_txq_mem
`default_nettype wire

// File: rtl/bus_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : bus_tx_queue
//  Description : Producer-side FIFO feeding a bus requester. The head word is
//                presented on data_in with req while the queue is non-empty;
//                a rising edge with req and gnt both high pops it. A push is
//                accepted when not full, or when a pop frees a slot on the
//                same edge. Pushes arriving while full without a pop are
//                dropped.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-low reset
//                wr_en    - push strobe
//                wr_data  - pushed word
//                full     - queue holds DEPTH words
//                count    - number of words held
//                req      - bus request (queue non-empty)
//                data_in  - head word, zero when empty
//                gnt      - bus grant, pops the head when req is high
//                overflow - sticky dropped-push flag
//  Config      : BUS_TXQ_OVERFLOW_EN - when defined, overflow latches on any
//                dropped push until reset; otherwise overflow is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_tx_queue
    import bus_pkg::*;
#(
    parameter int N     = c_bus_n,
    parameter int DEPTH = c_bus_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [N-1:0]               wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       req,
    output logic [N-1:0]               data_in,
    input  logic                       gnt,
    output logic                       overflow
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [N-1:0]       w_rd_data;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_full = (r_count == c_cnt_w'(DEPTH));
    assign w_pop  = (r_count != '0) && gnt;
    // A pop on the same edge frees the slot the push needs.
    assign w_push = wr_en && (!w_full || w_pop);
    assign w_drop = wr_en && w_full && !w_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset has priority: a push on a reset edge must not land in storage
    // in a way that could later surface, so gate the write with rst too.
    bus_txq_mem #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    assign full    = w_full;
    assign count   = r_count;
    assign req     = (r_count != '0);
    // Storage is unreset, so never expose it while empty.
    assign data_in = req ? w_rd_data : '0;

`ifdef BUS_TXQ_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign overflow      = 1'b0;
`endif

endmodule : bus_tx_queue
`default_nettype wire

// File: tb/tb_bus_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_tx_queue
//  Description : Self-checking bench for bus_tx_queue (N=8, DEPTH=4). A table
//                of directed vectors holds the inputs applied for one rising
//                edge and the outputs expected after that edge. A short
//                hand-written loop covers continuous push/pop across the
//                pointer wrap. Overflow expectations follow
//                BUS_TXQ_OVERFLOW_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_tx_queue;

`ifdef BUS_TXQ_OVERFLOW_EN
    localparam logic c_ov = 1'b1;
`else
    localparam logic c_ov = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       gnt;
        logic       exp_req;
        logic [7:0] exp_data;
        logic [2:0] exp_count;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       gnt = 1'b0;
    logic       full;
    logic [2:0] count;
    logic       req;
    logic [7:0] data_in;
    logic       overflow;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs[32];

    bus_tx_queue #(
        .N     (8),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .count    (count),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic we, input logic [7:0] wd,
                                input logic g, input logic er, input logic [7:0] ed,
                                input logic [2:0] ec, input logic ef, input logic eo);
        vec_t v;
        v.rst = r; v.wr_en = we; v.wr_data = wd; v.gnt = g;
        v.exp_req = er; v.exp_data = ed; v.exp_count = ec; v.exp_full = ef; v.exp_ovf = eo;
        return v;
    endfunction

    // Drive inputs away from the edge, step one rising edge, sample 1 ns later.
    task automatic apply(input logic r, input logic we, input logic [7:0] wd, input logic g);
        @(negedge clk);
        rst = r; wr_en = we; wr_data = wd; gnt = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic er, input logic [7:0] ed,
                         input logic [2:0] ec, input logic ef, input logic eo);
        n_vec++;
        if (req !== er || data_in !== ed || count !== ec || full !== ef || overflow !== eo) begin
            n_miss++;
            $display("FAIL %s: got req=%b data_in=%h count=%0d full=%b overflow=%b, expected req=%b data_in=%h count=%0d full=%b overflow=%b",
                     name, req, data_in, count, full, overflow, er, ed, ec, ef, eo);
        end
    endtask

    initial begin
        // reset
        vecs[0]  = mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'hFF, 1,  0, 8'h00, 0, 0, 0);
        // basic transfer
        vecs[2]  = mk(1, 1, 8'hAA, 0,  1, 8'hAA, 1, 0, 0);
        vecs[3]  = mk(1, 1, 8'hE5, 0,  1, 8'hAA, 2, 0, 0);
        vecs[4]  = mk(1, 0, 8'h00, 1,  1, 8'hE5, 1, 0, 0);
        vecs[5]  = mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        vecs[6]  = mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0);   // gnt without req
        // fill and overflow
        vecs[7]  = mk(1, 1, 8'h01, 0,  1, 8'h01, 1, 0, 0);
        vecs[8]  = mk(1, 1, 8'h02, 0,  1, 8'h01, 2, 0, 0);
        vecs[9]  = mk(1, 1, 8'h03, 0,  1, 8'h01, 3, 0, 0);
        vecs[10] = mk(1, 1, 8'h04, 0,  1, 8'h01, 4, 1, 0);
        vecs[11] = mk(1, 1, 8'h05, 0,  1, 8'h01, 4, 1, c_ov); // dropped
        vecs[12] = mk(1, 0, 8'h00, 0,  1, 8'h01, 4, 1, c_ov); // head held
        vecs[13] = mk(1, 0, 8'h00, 1,  1, 8'h02, 3, 0, c_ov);
        vecs[14] = mk(1, 0, 8'h00, 1,  1, 8'h03, 2, 0, c_ov);
        vecs[15] = mk(1, 0, 8'h00, 1,  1, 8'h04, 1, 0, c_ov);
        vecs[16] = mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0, c_ov);
        vecs[17] = mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0);    // clears overflow
        // push while full with pop
        vecs[18] = mk(1, 1, 8'h11, 0,  1, 8'h11, 1, 0, 0);
        vecs[19] = mk(1, 1, 8'h12, 0,  1, 8'h11, 2, 0, 0);
        vecs[20] = mk(1, 1, 8'h13, 0,  1, 8'h11, 3, 0, 0);
        vecs[21] = mk(1, 1, 8'h14, 0,  1, 8'h11, 4, 1, 0);
        vecs[22] = mk(1, 1, 8'h61, 1,  1, 8'h12, 4, 1, 0);
        vecs[23] = mk(1, 0, 8'h00, 1,  1, 8'h13, 3, 0, 0);
        vecs[24] = mk(1, 0, 8'h00, 1,  1, 8'h14, 2, 0, 0);
        vecs[25] = mk(1, 0, 8'h00, 1,  1, 8'h61, 1, 0, 0);
        vecs[26] = mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0);
        // reset mid-operation
        vecs[27] = mk(1, 1, 8'h71, 0,  1, 8'h71, 1, 0, 0);
        vecs[28] = mk(1, 1, 8'h72, 0,  1, 8'h71, 2, 0, 0);
        vecs[29] = mk(1, 1, 8'h73, 0,  1, 8'h71, 3, 0, 0);
        vecs[30] = mk(0, 1, 8'h7F, 0,  0, 8'h00, 0, 0, 0);
        vecs[31] = mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0);    // 7F not stored

        for (int i = 0; i < 32; i++) begin
            apply(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].gnt);
            check($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_data,
                  vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_ovf);
        end

        // Continuous push/pop with gnt held: each edge pops the previous word
        // and pushes the next, so the head advances by one per cycle with
        // count pinned at 1 across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 8'(8'h30 + i), 1'b1);
            check($sformatf("wrap%0d", i), 1'b1, 8'(8'h30 + i), 3'd1, 1'b0, 1'b0);
        end
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        check("wrap_drain", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // After the wrap, a fresh fill must still come out in order.
        apply(1'b1, 1'b1, 8'hC1, 1'b0);
        apply(1'b1, 1'b1, 8'hC2, 1'b0);
        check("post_wrap_fill", 1'b1, 8'hC1, 3'd2, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 8'h00, 1'b1);
        check("post_wrap_pop", 1'b1, 8'hC2, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_bus_tx_queue
`default_nettype wire

// File: doc/bus_tx_queue.md
BUS_TX_QUEUE -- requirements
Module: bus_tx_queue

Interface
REQ-001 SHALL have parameter N, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two and at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port wr_en, input, 1, producer push strobe.
REQ-006 SHALL have port wr_data, input, N, producer word.
REQ-007 SHALL have port full, output, 1, queue holds DEPTH words.
REQ-008 SHALL have port count, output, $clog2(DEPTH+1), number of words held.
REQ-009 SHALL have port req, output, 1, bus request; drives the bus requester's req input.
REQ-010 SHALL have port data_in, output, N, head word; drives the bus requester's data_in input.
REQ-011 SHALL have port gnt, input, 1, bus grant; high means the head word is driven onto the bus this cycle.
REQ-012 SHALL have port overflow, output, 1, sticky dropped-push flag (see Configuration).

Function
REQ-013 SHALL implement a FIFO ordering of words from wr_data to data_in.
REQ-014 SHALL assert req exactly when count is not zero; req is derived from registered state only.
REQ-015 SHALL drive data_in with the head entry when count is not zero, and all-zeros when empty.
REQ-016 SHALL complete a transfer (pop) on a rising edge where req and gnt are both high; gnt with req low is ignored.
REQ-017 SHALL accept a push on a rising edge where wr_en is high and either full is low, or a pop occurs on the same edge.
REQ-018 SHALL give a pushed word one-cycle latency into an empty queue: written at edge t, visible on req/data_in after edge t.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged and preserve order.
REQ-020 SHALL drop a push when full is high and no pop occurs on the same edge; queue contents stay unchanged.
REQ-021 SHALL wrap read and write pointers modulo DEPTH without a bubble cycle.
REQ-022 SHALL assert full exactly when count equals DEPTH.
REQ-023 SHALL hold data_in stable while req is high and gnt is low.

Reset
REQ-024 SHALL, when rst is low on a rising edge, clear pointers, count, and overflow, so that req=0, full=0, count=0, data_in=0 and overflow=0 after that edge.
REQ-025 SHALL give reset priority over simultaneous push or pop; queued words are discarded mid-operation and are not sent.
REQ-026 SHALL leave storage contents unreset; no output may expose them while empty.

Configuration
REQ-027 SHALL, with BUS_TXQ_OVERFLOW_EN defined, set overflow on any dropped push (REQ-020) and hold it until reset.
REQ-028 SHALL, without BUS_TXQ_OVERFLOW_EN, keep the overflow port present, tie it to 0, and implement no flag register; all other behaviour is identical.

Structure
REQ-029 SHALL take default N, default DEPTH, and the count-width constant from the shared package bus_pkg, which the bus requester also uses.
REQ-030 SHALL place the DEPTH x N register array, with its write port and asynchronous read port, in sub-module bus_txq_mem; pointer, count and flag logic stay in bus_tx_queue.

Verification
REQ-031 SHALL cover basic transfer: after reset, push AA and E5 with gnt=0 -> count=2, req=1, data_in=AA; then gnt=1 for two cycles -> data_in AA then E5, then req=0 and data_in=00.
REQ-032 SHALL cover fill and overflow: push 01,02,03,04,05 with gnt=0 and DEPTH=4 -> full=1, count=4, 05 dropped, overflow=1 with the macro and 0 without; draining gives 01..04.
REQ-033 SHALL cover push while full with pop: full queue, wr_en=1 with wr_data=61 and gnt=1 on the same edge -> count stays 4, overflow stays 0, 61 emerges last.
REQ-034 SHALL cover wrap: 10 push/pop pairs of 0x30+i with gnt=1 held -> output sequence in order, count never exceeds 1, no stall at the pointer wrap.
REQ-035 SHALL cover reset mid-operation: 3 words queued, rst=0 for one edge with wr_en=1 -> req=0, count=0, data_in=00, overflow=0, and the pushed word is not stored.
